// File: rtl/alu_wb_stage.sv
// -----------------------------------------------------------------------------
// alu_wb_stage
//
// This is the writeback stage placed between the ALU and the register file.
// ALU results are held in a 2-entry in-order FIFO. The head entry is written
// back on every cycle in which the register-file write port is free. When an
// entry leaves the FIFO, it can also update the condition codes {N,Z,P}.
// These codes produce the branch-taken signal for the current branch mask.
//
// Ports
//   clk          system clock; every state update happens on the rising edge
//   rst_n        synchronous active-low reset
//   in_valid     upstream ALU result is valid
//   in_ready     stage can accept a result this cycle (registered occupancy only)
//   in_result    ALU result, 16 bits
//   in_zero      ALU zero flag
//   in_negative  ALU negative flag
//   in_dr        destination register number
//   in_we        result is written to the register file
//   in_setcc     result updates the condition codes
//   wb_stall     register-file write port is busy this cycle
//   wb_en        register-file write strobe
//   wb_addr      register-file write address (0 when the FIFO is empty)
//   wb_data      register-file write data (0 when the FIFO is empty)
//   nzp          condition codes {N,Z,P}
//   br_cond      branch nzp mask from the instruction
//   br_taken     branch condition satisfied by the current nzp
// -----------------------------------------------------------------------------
module alu_wb_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_result,
  input  logic        in_zero,
  input  logic        in_negative,
  input  logic [2:0]  in_dr,
  input  logic        in_we,
  input  logic        in_setcc,
  input  logic        wb_stall,
  output logic        wb_en,
  output logic [2:0]  wb_addr,
  output logic [15:0] wb_data,
  output logic [2:0]  nzp,
  input  logic [2:0]  br_cond,
  output logic        br_taken
);

  typedef struct packed {
    logic [15:0] result;
    logic        zero;
    logic        negative;
    logic [2:0]  dr;
    logic        we;
    logic        setcc;
  } entry_t;

  entry_t      mem [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;
  logic [2:0]  nzp_q;

  logic        not_empty;
  logic        accept;
  logic        retire;
  entry_t      head;

  // When zero and negative are both set, N wins. Exactly one code bit is
  // set after any setcc retire.
  function automatic logic [2:0] flags_to_nzp(input logic zero, input logic negative);
    return {negative, zero & ~negative, ~zero & ~negative};
  endfunction

  assign not_empty = (count != 2'd0);
  // in_ready is derived only from registered occupancy. A retire in the same
  // cycle therefore cannot reopen a full FIFO, and there is no path from
  // wb_stall to in_ready.
  assign in_ready  = (count != 2'd2);
  assign accept    = in_valid & in_ready;
  assign retire    = not_empty & ~wb_stall;
  assign head      = mem[rd_ptr];

  // NOTE: the storage array has no reset. The pointers and count decide
  // which slots are live, so stale data in an unused slot is never observed.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= '{result:   in_result,
                       zero:     in_zero,
                       negative: in_negative,
                       dr:       in_dr,
                       we:       in_we,
                       setcc:    in_setcc};
    end
  end

  // NOTE: sequential state uses non-blocking assignments only. All flops then
  // sample the pre-edge values, whatever order the statements are written in.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      nzp_q  <= 3'b010;
    end else begin
      if (accept) wr_ptr <= ~wr_ptr;
      if (retire) rd_ptr <= ~rd_ptr;

      // When accept and retire happen together, occupancy stays the same.
      case ({accept, retire})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase

      if (retire && head.setcc) begin
        nzp_q <= flags_to_nzp(head.zero, head.negative);
      end
    end
  end

  // The writeback port is driven only from the registered head entry. A
  // freshly accepted result is therefore seen on the next cycle at the
  // earliest.
  // NOTE: each output gets a default before the conditional update, so this
  // block cannot infer a latch.
  always_comb begin
    wb_en   = 1'b0;
    wb_addr = 3'd0;
    wb_data = 16'd0;
    if (not_empty) begin
      wb_en   = head.we & ~wb_stall;
      wb_addr = head.dr;
      wb_data = head.result;
    end
  end

  assign nzp      = nzp_q;
  assign br_taken = |(br_cond & nzp_q);

endmodule

// File: tb/tb_alu_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_wb_stage
//
// Scoreboard bench for alu_wb_stage.
//
// The driver applies inputs #1 after each rising edge. At the following
// falling edge it records whether the handshake will complete. Just after
// that rising edge it pushes each accepted item into sb_q.
//
// The monitor samples all outputs on every falling edge and checks them
// against the reference model. In the model, sb_q is the list of results
// waiting for writeback, and m_nzp holds the expected condition codes. The
// monitor then applies the retire or reset that the coming edge will perform.
// -----------------------------------------------------------------------------
module tb_alu_wb_stage;

  typedef struct packed {
    logic [15:0] result;
    logic        zero;
    logic        negative;
    logic [2:0]  dr;
    logic        we;
    logic        setcc;
  } item_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_result;
  logic        in_zero;
  logic        in_negative;
  logic [2:0]  in_dr;
  logic        in_we;
  logic        in_setcc;
  logic        wb_stall;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic [2:0]  nzp;
  logic [2:0]  br_cond;
  logic        br_taken;

  int          checks   = 0;
  int          failures = 0;
  logic        mon_en   = 1'b0;
  item_t       sb_q[$];
  logic [2:0]  m_nzp    = 3'b010;

  alu_wb_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_result   (in_result),
    .in_zero     (in_zero),
    .in_negative (in_negative),
    .in_dr       (in_dr),
    .in_we       (in_we),
    .in_setcc    (in_setcc),
    .wb_stall    (wb_stall),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .nzp         (nzp),
    .br_cond     (br_cond),
    .br_taken    (br_taken)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference rule for the condition codes: negative takes priority, then
  // zero, and otherwise positive.
  function automatic logic [2:0] ref_nzp(input item_t it);
    if (it.negative) return 3'b100;
    if (it.zero)     return 3'b010;
    return 3'b001;
  endfunction

  function automatic item_t mk(input logic [15:0] r, input logic z, input logic n,
                               input logic [2:0] dr, input logic we, input logic sc);
    item_t it;
    it.result = r; it.zero = z; it.negative = n; it.dr = dr; it.we = we; it.setcc = sc;
    return it;
  endfunction

  function automatic item_t rand_item();
    return mk(16'($urandom), 1'($urandom), 1'($urandom), 3'($urandom),
              1'($urandom), 1'($urandom));
  endfunction

  // One clock cycle of stimulus. The task returns #1 after the rising edge,
  // with the scoreboard already updated.
  task automatic drive(input logic v, input item_t it, input logic stall,
                       input logic [2:0] bc, output logic acc);
    in_valid    = v;
    in_result   = it.result;
    in_zero     = it.zero;
    in_negative = it.negative;
    in_dr       = it.dr;
    in_we       = it.we;
    in_setcc    = it.setcc;
    wb_stall    = stall;
    br_cond     = bc;
    @(negedge clk);
    acc = v & in_ready & rst_n;
    @(posedge clk);
    #1;
    if (acc) sb_q.push_back(it);
  endtask

  task automatic idle(input logic stall, input logic [2:0] bc);
    logic acc;
    drive(1'b0, '0, stall, bc, acc);
  endtask

  // Retries one item, with a bounded number of attempts, until it is accepted.
  task automatic push_hold(input item_t it, input logic stall, input logic [2:0] bc);
    logic acc;
    acc = 1'b0;
    for (int t = 0; t < 8 && !acc; t++) drive(1'b1, it, stall, bc, acc);
    check("push_hold_accepted", 32'(acc), 32'd1);
  endtask

  // Monitor: checks the outputs, then advances the model for the coming edge.
  always @(negedge clk) begin
    item_t h;
    if (mon_en) begin
      check("in_ready", 32'(in_ready), 32'(sb_q.size() < 2));
      if (sb_q.size() > 0) begin
        h = sb_q[0];
        check("wb_en",   32'(wb_en),   32'(h.we & ~wb_stall));
        check("wb_addr", 32'(wb_addr), 32'(h.dr));
        check("wb_data", 32'(wb_data), 32'(h.result));
      end else begin
        check("wb_en_empty",   32'(wb_en),   32'd0);
        check("wb_addr_empty", 32'(wb_addr), 32'd0);
        check("wb_data_empty", 32'(wb_data), 32'd0);
      end
      check("nzp",      32'(nzp),      32'(m_nzp));
      check("br_taken", 32'(br_taken), 32'(|(br_cond & m_nzp)));
    end
    if (rst_n !== 1'b1) begin
      sb_q.delete();
      m_nzp = 3'b010;
    end else if (sb_q.size() > 0 && !wb_stall) begin
      h = sb_q.pop_front();
      if (h.setcc) m_nzp = ref_nzp(h);
    end
  end

  initial begin
    logic acc;
    rst_n = 1'b0;
    in_valid = 1'b0; in_result = '0; in_zero = 1'b0; in_negative = 1'b0;
    in_dr = '0; in_we = 1'b0; in_setcc = 1'b0; wb_stall = 1'b0; br_cond = 3'b000;

    // Reset state. The nzp mask 010 should make br_taken follow br_cond[1].
    idle(1'b0, 3'b010);
    mon_en = 1'b1;
    idle(1'b1, 3'b010);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_nzp",      32'(nzp),      32'h2);
    check("reset_br_taken", 32'(br_taken), 32'd1);
    rst_n = 1'b1;

    // Single result: written back on the next cycle, then nzp becomes N.
    drive(1'b1, mk(16'h8001, 1'b0, 1'b1, 3'd3, 1'b1, 1'b1), 1'b0, 3'b100, acc);
    check("single_accept", 32'(acc), 32'd1);
    check("single_wb_en", 32'(wb_en), 32'd1);
    check("single_wb_data", 32'(wb_data), 32'h8001);
    idle(1'b0, 3'b100);
    check("single_nzp", 32'(nzp), 32'h4);
    check("single_br_taken", 32'(br_taken), 32'd1);

    // Backpressure: the first two pushes are accepted and the third is refused.
    drive(1'b1, mk(16'h1111, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0), 1'b1, 3'b111, acc);
    drive(1'b1, mk(16'h2222, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0), 1'b1, 3'b111, acc);
    check("bp_full_in_ready", 32'(in_ready), 32'd0);
    drive(1'b1, mk(16'h3333, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0), 1'b1, 3'b111, acc);
    check("bp_third_refused", 32'(acc), 32'd0);
    push_hold(mk(16'h3333, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0), 1'b0, 3'b111);
    repeat (3) idle(1'b0, 3'b111);
    check("bp_drained", 32'(wb_en), 32'd0);

    // Flag rules, including the case where setcc=0 leaves nzp unchanged.
    push_hold(mk(16'h0000, 1'b1, 1'b0, 3'd5, 1'b1, 1'b1), 1'b0, 3'b010);
    idle(1'b0, 3'b010);
    check("flag_zero", 32'(nzp), 32'h2);
    push_hold(mk(16'h0000, 1'b1, 1'b1, 3'd5, 1'b1, 1'b1), 1'b0, 3'b010);
    idle(1'b0, 3'b010);
    check("flag_zero_neg", 32'(nzp), 32'h4);
    push_hold(mk(16'h0005, 1'b0, 1'b0, 3'd6, 1'b1, 1'b0), 1'b0, 3'b010);
    idle(1'b0, 3'b010);
    check("flag_nosetcc", 32'(nzp), 32'h4);

    // No-write entry: it still retires and still updates the condition codes.
    push_hold(mk(16'h0042, 1'b0, 1'b0, 3'd7, 1'b0, 1'b1), 1'b0, 3'b001);
    check("nowrite_wb_en", 32'(wb_en), 32'd0);
    idle(1'b0, 3'b001);
    check("nowrite_nzp", 32'(nzp), 32'h1);
    check("nowrite_empty", 32'(in_ready), 32'd1);

    // Streaming: one accept per cycle, with no refusal.
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, rand_item(), 1'b0, 3'($urandom), acc);
      check("stream_accept", 32'(acc), 32'd1);
    end
    idle(1'b0, 3'b000);

    // Reset mid-operation: both buffered entries are discarded.
    drive(1'b1, mk(16'hAAAA, 1'b0, 1'b1, 3'd1, 1'b1, 1'b1), 1'b1, 3'b010, acc);
    drive(1'b1, mk(16'hBBBB, 1'b0, 1'b1, 3'd2, 1'b1, 1'b1), 1'b1, 3'b010, acc);
    rst_n = 1'b0;
    idle(1'b1, 3'b010);
    rst_n = 1'b1;
    wb_stall = 1'b0;
    #1;
    check("midrst_wb_en", 32'(wb_en), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_nzp", 32'(nzp), 32'h2);
    repeat (3) idle(1'b0, 3'b010);

    // Randomised traffic, with an occasional reset.
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      drive(1'($urandom), rand_item(), ($urandom_range(0, 3) == 0), 3'($urandom), acc);
    end
    rst_n = 1'b1;
    repeat (4) idle(1'b0, 3'b000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_wb_stage.md
ALU_WB_STAGE -- requirements
Module: alu_wb_stage

Interface
REQ-001 SHALL have exactly one clock and one reset; reset is synchronous and active-low.
REQ-002 SHALL provide ports (name  direction  width  meaning):
  clk  input  1  system clock, all state updates on rising edge
  rst_n  input  1  synchronous active-low reset
  in_valid  input  1  upstream ALU result valid
  in_ready  output  1  stage can accept a result this cycle
  in_result  input  16  ALU out
  in_zero  input  1  ALU zero flag
  in_negative  input  1  ALU negative flag
  in_dr  input  3  destination register number
  in_we  input  1  result is written to register file
  in_setcc  input  1  result updates condition codes
  wb_stall  input  1  register-file write port busy this cycle
  wb_en  output  1  register-file write strobe
  wb_addr  output  3  register-file write address
  wb_data  output  16  register-file write data
  nzp  output  3  condition codes {N,Z,P}
  br_cond  input  3  branch nzp mask from instruction
  br_taken  output  1  branch condition satisfied

Function
REQ-003 SHALL buffer accepted results in a 2-entry in-order FIFO (entry = result, zero, negative, dr, we, setcc).
REQ-004 SHALL accept an entry on a rising edge where in_valid=1 and in_ready=1; no other input is captured.
REQ-005 SHALL drive in_ready=1 iff FIFO occupancy is 0 or 1; in_ready SHALL depend only on registered occupancy (no combinational path from wb_stall).
REQ-006 SHALL retire the head entry on a rising edge where occupancy>0 and wb_stall=0.
REQ-007 SHALL drive wb_en = (occupancy>0) & head.we & !wb_stall, combinationally; wb_addr=head.dr and wb_data=head.result whenever occupancy>0, else 0.
REQ-008 SHALL have a minimum latency of 1 cycle: an entry accepted at edge k drives wb_en no earlier than the cycle following edge k (no input-to-wb bypass).
REQ-009 SHALL, on simultaneous accept and retire, keep occupancy unchanged and preserve order.
REQ-010 SHALL, at occupancy 2, deassert in_ready even if a retire occurs in the same cycle.
REQ-011 SHALL, when a retiring head has setcc=1, load nzp on that edge: N=negative, Z=zero&!negative, P=!zero&!negative.
REQ-012 SHALL treat zero=1 and negative=1 together as N (nzp=3'b100).
REQ-013 SHALL hold nzp unchanged when the retiring head has setcc=0, when no retire occurs, and while wb_stall=1.
REQ-014 SHALL retire entries with we=0 (occupancy decrements, wb_en stays 0, setcc still honoured).
REQ-015 SHALL drive br_taken = |(br_cond & nzp) combinationally from the registered nzp.
REQ-016 SHALL keep FIFO pointers 1 bit wide each with wrap-around, occupancy 2 bits, never exceeding 2 or underflowing.

Reset
REQ-017 SHALL, on a rising edge with rst_n=0, set occupancy=0, pointers=0, nzp=3'b010, regardless of any other input.
REQ-018 SHALL, during and after reset, drive wb_en=0, wb_addr=0, wb_data=0, in_ready=1, br_taken=br_cond[1].
REQ-019 SHALL discard buffered entries when reset is asserted mid-operation; none is written back afterward.

Verification
REQ-020 Single result: push result=16'h8001, negative=1, dr=3, we=1, setcc=1 -> next cycle wb_en=1, wb_addr=3, wb_data=16'h8001; after that edge nzp=3'b100, br_taken=1 for br_cond=3'b100.
REQ-021 Backpressure: wb_stall=1, push 3 consecutive results -> first two accepted, in_ready=0 on third; release stall -> three writebacks in push order, one per cycle.
REQ-022 Flag rules: retire zero=1/negative=0 -> nzp=3'b010; retire zero=1/negative=1 -> nzp=3'b100; retire setcc=0 -> nzp unchanged.
REQ-023 Streaming: in_valid=1 every cycle, wb_stall=0 -> one retire per cycle, occupancy stays 1, in_ready stays 1, no entry lost or duplicated.
REQ-024 Reset mid-operation: two entries buffered, wb_stall=1, assert rst_n=0 one edge -> occupancy=0, nzp=3'b010, wb_en=0; no stale writeback after release.
REQ-025 No-write entry: push we=0, setcc=1, zero=0, negative=0 -> wb_en stays 0, occupancy returns to 0, nzp=3'b001.
